mm_result_drain_buffer: RTL

//  Downstream of the MXU: captures skew-arriving per-lane results (lane i emits row i, cols 0..col_len in order),

---
 rtl/mm_pkg.sv | 35 +++
 rtl/mm_res_lane_collector.sv | 56 +++++
 rtl/mm_result_drain_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared constants, FSM state and job configuration types for the MXU result drain buffer.
package mm_pkg;

    localparam int LANES      = 16;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int IDX_W      = 4;
    localparam int CFG_ADDR_W = 12;
    localparam int LINE_W     = LANES * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]      row_len;
        logic [IDX_W-1:0]      col_len;
        logic [CFG_ADDR_W-1:0] addr;
    } cfg_t;

    // Byte enables for one row; bits pushed beyond byte 15 are simply lost (no wrap).
    function automatic logic [LANES-1:0] strb_for(input cfg_t cfg);
        logic [2*LANES-1:0] mask;
        mask = (32'd1 << ({1'b0, cfg.col_len} + 5'd1)) - 32'd1;
        mask = mask << cfg.addr[IDX_W-1:0];
        return mask[LANES-1:0];
    endfunction

    function automatic logic cfg_overflow(input cfg_t cfg);
        return ({1'b0, cfg.addr[IDX_W-1:0]} + {1'b0, cfg.col_len}) > 5'd15;
    endfunction

endpackage

// File: rtl/mm_res_lane_collector.sv
// One systolic lane: gathers its row of results column by column and flags completion.
// With MM_RES_RELU_EN defined, negative elements are stored as zero.
module mm_res_lane_collector
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              capture_en,
    input  logic              lane_active,
    input  logic [IDX_W-1:0]  col_len,
    input  logic              vld,
    input  logic [DATA_W-1:0] data,
    output logic [LINE_W-1:0] row,
    output logic              complete,
    output logic              err
);

    logic [LINE_W-1:0] row_reg;
    logic [IDX_W-1:0]  col_cnt_reg;
    logic              complete_reg;
    logic              accept;
    logic [DATA_W-1:0] elem;

    // Anything arriving outside a live, unfinished row is dropped and reported.
    assign accept = vld && capture_en && lane_active && !complete_reg;
    assign err    = vld && !accept;

`ifdef MM_RES_RELU_EN
    assign elem = data[DATA_W-1] ? '0 : data;
`else
    assign elem = data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg      <= '0;
            col_cnt_reg  <= '0;
            complete_reg <= 1'b0;
        end else if (start) begin
            row_reg      <= '0;
            col_cnt_reg  <= '0;
            complete_reg <= 1'b0;
        end else if (accept) begin
            row_reg[col_cnt_reg * DATA_W +: DATA_W] <= elem;
            col_cnt_reg <= col_cnt_reg + 1'b1;
            if (col_cnt_reg == col_len) begin
                complete_reg <= 1'b1;
            end
        end
    end

    assign row      = row_reg;
    assign complete = complete_reg;

endmodule

// File: rtl/mm_result_drain_buffer.sv
// Deskews per-lane MXU results into a 16-row line buffer and drains finished rows in order to RAM.
// Optional build macro MM_RES_RELU_EN applies ReLU to captured elements.
module mm_result_drain_buffer
    import mm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mm_res_cfg_vld,
    input  logic [IDX_W-1:0]      mm_res_cfg_row_len,
    input  logic [IDX_W-1:0]      mm_res_cfg_col_len,
    input  logic [CFG_ADDR_W-1:0] mm_res_cfg_addr,
    input  logic [LANES-1:0]      mxu_res_vld,
    input  logic [LINE_W-1:0]     mxu_res_data,
    output logic                  ram_wr_vld,
    input  logic                  ram_wr_rdy,
    output logic [ADDR_W-1:0]     ram_wr_addr,
    output logic [LINE_W-1:0]     ram_wr_data,
    output logic [LANES-1:0]      ram_wr_strb,
    output logic                  mm_res_busy,
    output logic                  mm_res_done,
    output logic                  mm_res_err
);

    state_t            state_reg, state_next;
    cfg_t              cfg_reg, cfg_in;
    logic [IDX_W-1:0]  wr_row_reg;
    logic              err_reg;
    logic              accept_cfg;
    logic              handshake;
    logic              last_row;
    logic [6:0]        data_shift;
    logic [LINE_W-1:0] row_data [LANES];
    logic [LANES-1:0]  row_complete;
    logic [LANES-1:0]  lane_err;

    assign cfg_in.row_len = mm_res_cfg_row_len;
    assign cfg_in.col_len = mm_res_cfg_col_len;
    assign cfg_in.addr    = mm_res_cfg_addr;

    assign accept_cfg = (state_reg == IDLE) && mm_res_cfg_vld;
    assign handshake  = ram_wr_vld && ram_wr_rdy;
    assign last_row   = handshake && (wr_row_reg == cfg_reg.row_len);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            mm_res_lane_collector u_lane (
                .clk         (clk),
                .rst         (rst),
                .start       (accept_cfg),
                .capture_en  (state_reg == RUN),
                .lane_active (4'(gi) <= cfg_reg.row_len),
                .col_len     (cfg_reg.col_len),
                .vld         (mxu_res_vld[gi]),
                .data        (mxu_res_data[gi*DATA_W +: DATA_W]),
                .row         (row_data[gi]),
                .complete    (row_complete[gi]),
                .err         (lane_err[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mm_res_cfg_vld) state_next = RUN;
            RUN:     if (last_row)       state_next = DONE;
            DONE:                        state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cfg_reg    <= '0;
            wr_row_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept_cfg) begin
                cfg_reg    <= cfg_in;
                wr_row_reg <= '0;
                err_reg    <= cfg_overflow(cfg_in) | (|lane_err);
            end else begin
                if (handshake) begin
                    wr_row_reg <= wr_row_reg + 1'b1;
                end
                if (|lane_err) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    // A completed row cannot be rewritten, so the presented write stays stable under backpressure.
    assign ram_wr_vld  = (state_reg == RUN) && row_complete[wr_row_reg];
    assign data_shift  = 7'(cfg_reg.addr[IDX_W-1:0]) * 7'(DATA_W);
    assign ram_wr_addr = ram_wr_vld ? cfg_reg.addr[CFG_ADDR_W-1:IDX_W] + {4'b0, wr_row_reg} : '0;
    assign ram_wr_data = ram_wr_vld ? row_data[wr_row_reg] << data_shift : '0;
    assign ram_wr_strb = ram_wr_vld ? strb_for(cfg_reg) : '0;

    assign mm_res_busy = (state_reg != IDLE);
    assign mm_res_done = (state_reg == DONE);
    assign mm_res_err  = err_reg;

endmodule
